// File: rtl/lzw_pkg.sv
// Shared constants and FSM encoding for the LZW code unwinder.
package lzw_pkg;

  localparam int unsigned DEFAULT_CODE_WIDTH = 12;
  localparam int unsigned DEFAULT_CHAR_WIDTH = 8;
  // First code that refers to a dictionary entry rather than a literal.
  localparam int unsigned FIRST_CODE = 1 << DEFAULT_CHAR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    TEST,
    PUSH,
    EMIT
  } state_t;

endpackage

// File: rtl/lzw_code_unwinder_if.sv
// Code input handshake and decoded symbol stream of the unwinder.
interface lzw_code_unwinder_if
  import lzw_pkg::*;
#(
  parameter int unsigned CODE_WIDTH = DEFAULT_CODE_WIDTH,
  parameter int unsigned CHAR_WIDTH = DEFAULT_CHAR_WIDTH
);
  logic                  code_valid;
  logic                  code_ready;
  logic [CODE_WIDTH-1:0] code;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHAR_WIDTH-1:0] out_char;
  logic                  out_last;
  logic [CHAR_WIDTH-1:0] first_char;

  modport slave (
    input  code_valid, code, out_ready,
    output code_ready, out_valid, out_char, out_last, first_char
  );

  modport master (
    output code_valid, code, out_ready,
    input  code_ready, out_valid, out_char, out_last, first_char
  );
endinterface

// File: rtl/lzw_dict_ram.sv
// Dictionary storage: one write port, one registered read port.
module lzw_dict_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned DEPTH      = 3840
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Append a dictionary entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data appears the cycle after the request.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lzw_code_unwinder.sv
// Walks an LZW code back through its prefix chain onto a LIFO stack,
// then streams the stacked symbols out in forward order.
module lzw_code_unwinder
  import lzw_pkg::*;
#(
  parameter int unsigned CODE_WIDTH = DEFAULT_CODE_WIDTH,
  parameter int unsigned CHAR_WIDTH = DEFAULT_CHAR_WIDTH,
  parameter int unsigned MAX_LEN    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  lzw_code_unwinder_if.slave    bus,
  input  logic                  dict_we,
  input  logic [CODE_WIDTH-1:0] dict_prefix,
  input  logic [CHAR_WIDTH-1:0] dict_suffix,
  input  logic                  dict_clear,
  output logic                  dict_full,
  output logic                  err_unknown,
  output logic                  err_overflow
);

  localparam int unsigned FIRST = 1 << CHAR_WIDTH;
  localparam int unsigned DEPTH = (1 << CODE_WIDTH) - FIRST;
  localparam int unsigned NW    = CODE_WIDTH + 1;
  localparam int unsigned CW    = $clog2(MAX_LEN + 1);
  localparam int unsigned IW    = $clog2(MAX_LEN);
  localparam logic [NW-1:0] NC_FIRST = NW'(FIRST);
  localparam logic [NW-1:0] NC_FULL  = NW'(1 << CODE_WIDTH);

  state_t                         state, state_nx;
  logic [CODE_WIDTH-1:0]          cur, cur_nx;
  logic [NW-1:0]                  next_code;
  logic [CHAR_WIDTH-1:0]          stack [MAX_LEN];
  logic [CW-1:0]                  count;
  logic [CODE_WIDTH+CHAR_WIDTH-1:0] rd_data;
  logic [CODE_WIDTH-1:0]          rd_prefix;
  logic [CHAR_WIDTH-1:0]          rd_suffix;
  logic [CHAR_WIDTH-1:0]          push_sym;
  logic accept, stack_full, rd_en, do_push, do_pop, load_cur, load_first;
  logic set_unknown, set_overflow, dict_wr;

  assign accept     = bus.code_valid && bus.code_ready;
  assign stack_full = (count == CW'(MAX_LEN));
  assign dict_full  = (next_code == NC_FULL);
  assign dict_wr    = dict_we && !dict_full && !dict_clear;
  assign {rd_prefix, rd_suffix} = rd_data;

  assign bus.code_ready = rst && !dict_clear && (state == IDLE);
  assign bus.out_valid  = (state == EMIT);
  assign bus.out_last   = (state == EMIT) && (count == CW'(1));
  assign bus.out_char   = (state == EMIT) ? stack[IW'(count - CW'(1))] : '0;

  lzw_dict_ram #(
    .ADDR_WIDTH(CODE_WIDTH),
    .DATA_WIDTH(CODE_WIDTH + CHAR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_dict (
    .clk  (clk),
    .we   (dict_wr),
    .waddr(CODE_WIDTH'(next_code - NC_FIRST)),
    .wdata({dict_prefix, dict_suffix}),
    .re   (rd_en),
    .raddr(cur - CODE_WIDTH'(FIRST)),
    .rdata(rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and per-cycle datapath controls.
  always_comb begin
    state_nx     = state;
    cur_nx       = cur;
    push_sym     = '0;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    load_cur     = 1'b0;
    load_first   = 1'b0;
    rd_en        = 1'b0;
    set_unknown  = 1'b0;
    set_overflow = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if ({1'b0, bus.code} >= next_code) begin
            set_unknown = 1'b1;
          end else begin
            load_cur = 1'b1;
            cur_nx   = bus.code;
            state_nx = TEST;
          end
        end
      end
      TEST: begin
        if (cur < CODE_WIDTH'(FIRST)) begin
          do_push    = 1'b1;
          push_sym   = cur[CHAR_WIDTH-1:0];
          load_first = 1'b1;
          state_nx   = EMIT;
        end else begin
          rd_en    = 1'b1;
          state_nx = PUSH;
        end
      end
      PUSH: begin
        do_push  = 1'b1;
        push_sym = rd_suffix;
        load_cur = 1'b1;
        cur_nx   = rd_prefix;
        state_nx = TEST;
      end
      EMIT: begin
        if (bus.out_ready) begin
          do_pop = 1'b1;
          if (count == CW'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A push into a full stack abandons the whole string.
    if (do_push && stack_full) begin
      set_overflow = 1'b1;
      state_nx     = IDLE;
    end
    if (dict_clear) state_nx = IDLE;
  end

  // Walk pointer, stack depth, first symbol and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur          <= '0;
      count        <= '0;
      bus.first_char <= '0;
      err_unknown  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (dict_clear) begin
      count        <= '0;
      err_unknown  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (set_unknown) err_unknown <= 1'b1;
      if (set_overflow) begin
        err_overflow <= 1'b1;
        count        <= '0;
      end else if (do_push) begin
        count <= count + CW'(1);
      end else if (do_pop) begin
        count <= count - CW'(1);
      end
      if (load_cur) cur <= cur_nx;
      if (load_first && !set_overflow) bus.first_char <= push_sym;
    end
  end

  // Stack storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push && !stack_full) stack[IW'(count)] <= push_sym;
  end

  // Dictionary fill pointer.
  always_ff @(posedge clk) begin
    if (!rst)            next_code <= NC_FIRST;
    else if (dict_clear) next_code <= NC_FIRST;
    else if (dict_wr)    next_code <= next_code + NW'(1);
  end

endmodule

// File: tb/tb_lzw_code_unwinder.sv
// Scoreboard bench for lzw_code_unwinder: a default instance and a MAX_LEN=4
// instance sharing one dictionary write stream.
module tb_lzw_code_unwinder;
  import lzw_pkg::*;

  localparam int unsigned CW = DEFAULT_CODE_WIDTH;
  localparam int unsigned HW = DEFAULT_CHAR_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          dict_we = 1'b0;
  logic          dict_clear = 1'b0;
  logic [CW-1:0] dict_prefix = '0;
  logic [HW-1:0] dict_suffix = '0;
  logic full1, unk1, ovf1, full2, unk2, ovf2;

  lzw_code_unwinder_if #(.CODE_WIDTH(CW), .CHAR_WIDTH(HW)) bus1 ();
  lzw_code_unwinder_if #(.CODE_WIDTH(CW), .CHAR_WIDTH(HW)) bus2 ();

  lzw_code_unwinder #(.CODE_WIDTH(CW), .CHAR_WIDTH(HW), .MAX_LEN(64)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .dict_we(dict_we), .dict_prefix(dict_prefix), .dict_suffix(dict_suffix),
    .dict_clear(dict_clear), .dict_full(full1),
    .err_unknown(unk1), .err_overflow(ovf1)
  );

  lzw_code_unwinder #(.CODE_WIDTH(CW), .CHAR_WIDTH(HW), .MAX_LEN(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .dict_we(dict_we), .dict_prefix(dict_prefix), .dict_suffix(dict_suffix),
    .dict_clear(dict_clear), .dict_full(full2),
    .err_unknown(unk2), .err_overflow(ovf2)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [HW:0] q1[$];
  logic [HW:0] q2[$];
  logic          hold1 = 1'b0;
  logic [HW-1:0] hold_char1 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor for the default instance, including stall stability.
  always @(negedge clk) begin
    if (rst) begin
      if (hold1) check("dut1_stall_hold", bus1.out_char, hold_char1);
      if (bus1.out_valid && q1.size() == 0) check("dut1_spurious_out", bus1.out_valid, 0);
      else if (bus1.out_valid && bus1.out_ready) begin
        check("dut1_char", bus1.out_char, q1[0][HW-1:0]);
        check("dut1_last", bus1.out_last, q1[0][HW]);
        void'(q1.pop_front());
      end
      hold1      <= bus1.out_valid && !bus1.out_ready;
      hold_char1 <= bus1.out_char;
    end else begin
      hold1 <= 1'b0;
    end
  end

  // Output monitor for the short-stack instance.
  always @(negedge clk) begin
    if (rst) begin
      if (bus2.out_valid && q2.size() == 0) check("dut2_spurious_out", bus2.out_valid, 0);
      else if (bus2.out_valid && bus2.out_ready) begin
        check("dut2_char", bus2.out_char, q2[0][HW-1:0]);
        check("dut2_last", bus2.out_last, q2[0][HW]);
        void'(q2.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned which, input logic [CW-1:0] c);
    int unsigned n = 0;
    logic rdy;
    if (which == 1) begin bus1.code = c; bus1.code_valid = 1'b1; end
    else            begin bus2.code = c; bus2.code_valid = 1'b1; end
    @(negedge clk);
    rdy = (which == 1) ? bus1.code_ready : bus2.code_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (which == 1) ? bus1.code_ready : bus2.code_ready;
    end
    if (!rdy) check("accept_timeout", rdy, 1);
    tick();
    bus1.code_valid = 1'b0;
    bus2.code_valid = 1'b0;
  endtask

  task automatic latency1(output int unsigned lat);
    lat = 0;
    @(negedge clk);
    while (!bus1.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_drain(input int unsigned which);
    int unsigned n = 0;
    int sz;
    sz = (which == 1) ? q1.size() : q2.size();
    while (sz != 0 && n < 300) begin
      @(negedge clk);
      n++;
      sz = (which == 1) ? q1.size() : q2.size();
    end
    check("queue_drain", sz, 0);
    tick();
  endtask

  task automatic dict_write(input logic [CW-1:0] p, input logic [HW-1:0] s);
    dict_prefix = p;
    dict_suffix = s;
    dict_we     = 1'b1;
    tick();
    dict_we     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    bus1.code_valid = 1'b0; bus1.code = '0; bus1.out_ready = 1'b1;
    bus2.code_valid = 1'b0; bus2.code = '0; bus2.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_code_ready", bus1.code_ready, 0);
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_out_last", bus1.out_last, 0);
    check("rst_out_char", bus1.out_char, 0);
    check("rst_first_char", bus1.first_char, 0);
    check("rst_errors", {unk1, ovf1}, 0);
    check("rst_dict_full", full1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus1.code_ready, 1);
    tick();

    // Literal code: single symbol, one cycle of latency
    q1.push_back({1'b1, 8'h41});
    send(1, 12'h041);
    latency1(lat);
    check("lat_literal", lat, 1);
    check("first_char_literal", bus1.first_char, 8'h41);
    wait_drain(1);

    // Two-level chain
    dict_write(12'h041, 8'h42);
    dict_write(12'd256, 8'h43);
    q1.push_back({1'b0, 8'h41}); q1.push_back({1'b0, 8'h42}); q1.push_back({1'b1, 8'h43});
    send(1, 12'd257);
    latency1(lat);
    check("lat_len3", lat, 5);
    check("first_char_len3", bus1.first_char, 8'h41);
    wait_drain(1);

    // Back-pressure after the first symbol
    q1.push_back({1'b0, 8'h41}); q1.push_back({1'b0, 8'h42}); q1.push_back({1'b1, 8'h43});
    send(1, 12'd257);
    latency1(lat);
    tick();
    bus1.out_ready = 1'b0;
    @(negedge clk);
    check("stall_char", bus1.out_char, 8'h42);
    tick();
    tick();
    bus1.out_ready = 1'b1;
    wait_drain(1);

    // Code not yet in the dictionary
    check("unknown_before", unk1, 0);
    send(1, 12'd258);
    @(negedge clk);
    check("err_unknown", unk1, 1);
    check("ready_after_unknown", bus1.code_ready, 1);
    repeat (5) tick();

    // Stack overflow on the MAX_LEN=4 instance
    dict_write(12'd257, 8'h44);
    dict_write(12'd258, 8'h45);
    q2.push_back({1'b0, 8'h41}); q2.push_back({1'b0, 8'h42});
    q2.push_back({1'b0, 8'h43}); q2.push_back({1'b1, 8'h44});
    send(2, 12'd258);
    wait_drain(2);
    check("ovf_at_max_len", ovf2, 0);
    send(2, 12'd259);
    repeat (12) tick();
    check("err_overflow", ovf2, 1);
    @(negedge clk);
    check("ready_after_overflow", bus2.code_ready, 1);
    tick();
    q2.push_back({1'b1, 8'h5A});
    send(2, 12'h05A);
    wait_drain(2);

    // Fill to the last entry, then one more
    dict_prefix = 12'h030;
    dict_suffix = 8'h31;
    dict_we = 1'b1;
    repeat (4095 - 260) tick();
    dict_we = 1'b0;
    check("full_before_last", full1, 0);
    dict_write(12'h041, 8'h5A);
    check("dict_full_1", full1, 1);
    check("dict_full_2", full2, 1);
    dict_write(12'h042, 8'h42);
    check("full_after_ignored_we", full1, 1);
    q1.push_back({1'b0, 8'h41}); q1.push_back({1'b1, 8'h5A});
    send(1, 12'd4095);
    wait_drain(1);

    // Clear dictionary and errors
    dict_clear = 1'b1;
    tick();
    dict_clear = 1'b0;
    check("clear_full", full1, 0);
    check("clear_unknown", unk1, 0);
    check("clear_overflow", ovf2, 0);
    send(1, 12'd256);
    @(negedge clk);
    check("unknown_after_clear", unk1, 1);
    tick();

    // Reset in the middle of a walk discards the string
    dict_write(12'h041, 8'h42);
    dict_write(12'd256, 8'h43);
    send(1, 12'd257);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (8) tick();
    check("reset_clears_unknown", unk1, 0);
    check("ready_after_mid_reset", bus1.code_ready, 1);
    send(1, 12'd256);
    @(negedge clk);
    check("dict_invalid_after_reset", unk1, 1);
    tick();

    check("q1_empty_end", q1.size(), 0);
    check("q2_empty_end", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lzw_code_unwinder.md
LZW_CODE_UNWINDER -- requirements
Module: lzw_code_unwinder

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 12, code and dictionary-address width.
REQ-002 SHALL have parameter CHAR_WIDTH, default 8, symbol width; literal codes are 0..2^CHAR_WIDTH-1.
REQ-003 SHALL have parameter MAX_LEN, default 64, maximum string length held in the output stack.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports code_valid input 1, code_ready output 1, code input CODE_WIDTH; these form the input code handshake.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_char output CHAR_WIDTH, out_last output 1; these form the decoded symbol stream.
REQ-008 SHALL have port first_char  output  CHAR_WIDTH  first symbol of the current string, needed by the parent decoder.
REQ-009 SHALL have ports dict_we input 1, dict_prefix input CODE_WIDTH, dict_suffix input CHAR_WIDTH; these append one dictionary entry.
REQ-010 SHALL have port dict_clear  input  1  resets dictionary fill and errors.
REQ-011 SHALL have outputs dict_full 1, err_unknown 1, err_overflow 1.

Function
REQ-012 SHALL accept a code on the cycle code_valid && code_ready; code_ready = 1 only in IDLE.
REQ-013 SHALL implement FSM states IDLE, TEST, PUSH, EMIT.
REQ-014 SHALL, in IDLE on accept, set cur = code and go to TEST; if code >= next_code, it SHALL instead set err_unknown, stay in IDLE and produce no output.
REQ-015 SHALL, in TEST with cur < 2^CHAR_WIDTH, push cur[CHAR_WIDTH-1:0], load first_char with that symbol and go to EMIT.
REQ-016 SHALL, in TEST otherwise, issue a synchronous dictionary read of cur and go to PUSH.
REQ-017 SHALL, in PUSH, push the read suffix, set cur = read prefix and go to TEST.
REQ-018 SHALL take 2*(L-1)+1 cycles from accept to the first out_valid for a string of length L.
REQ-019 SHALL, in EMIT, drive out_valid = 1 with out_char = stack top; each cycle out_valid && out_ready pops one symbol; out_char SHALL be held stable while out_ready = 0.
REQ-020 SHALL assert out_last with the final symbol (stack count == 1); after that pop it SHALL return to IDLE.
REQ-021 SHALL, on a push with stack count == MAX_LEN, set err_overflow, empty the stack, go to IDLE and emit nothing.
REQ-022 SHALL, on dict_we, write {dict_prefix, dict_suffix} at next_code and increment next_code; next_code starts at 2^CHAR_WIDTH.
REQ-023 SHALL assert dict_full when next_code == 2^CODE_WIDTH; dict_we while full SHALL be ignored.
REQ-024 SHALL accept dict_we in any FSM state.
REQ-025 SHALL give dict_clear priority over dict_we; dict_clear SHALL set next_code = 2^CHAR_WIDTH, clear both errors, empty the stack and force IDLE from any state.
REQ-026 SHALL keep err_unknown and err_overflow sticky until dict_clear or reset; an error SHALL NOT block acceptance of later codes.

Reset
REQ-027 SHALL, while rst = 0, set state = IDLE, stack count = 0, next_code = 2^CHAR_WIDTH, out_valid = 0, out_last = 0, out_char = 0, first_char = 0, err_unknown = 0, err_overflow = 0, dict_full = 0, and code_ready = 0.
REQ-028 SHALL assert code_ready in the first cycle after rst returns to 1.
REQ-029 SHALL, when reset arrives mid-walk or mid-emit, discard the string without completing it.
REQ-030 SHALL NOT clear dictionary RAM contents on reset; entries are invalid only by virtue of next_code.

Structure
REQ-031 SHALL place CODE_WIDTH and CHAR_WIDTH defaults, the FIRST_CODE constant and the FSM state enum in shared package lzw_pkg.
REQ-032 SHALL instantiate sub-module lzw_dict_ram: simple dual-port RAM, one write port and one synchronous read port with 1-cycle latency, depth 2^CODE_WIDTH - 2^CHAR_WIDTH.
REQ-033 SHALL implement the LIFO stack as an internal register array of MAX_LEN entries with a count register.

Verification
REQ-034 SHALL cover: code 0x41 after reset -> out_char 0x41 with out_last = 1 and first_char 0x41, out_valid one cycle after accept.
REQ-035 SHALL cover: write 256 = {0x41, 0x42} and 257 = {256, 0x43}, then code 257 -> outputs 0x41, 0x42, 0x43, out_last on 0x43, first out_valid 5 cycles after accept.
REQ-036 SHALL cover: out_ready held low 3 cycles after the first symbol of code 257 -> 0x42 held stable, no symbol lost or duplicated.
REQ-037 SHALL cover: code 258 while next_code = 258 -> err_unknown = 1, no out_valid, code_ready = 1 the next cycle.
REQ-038 SHALL cover: MAX_LEN = 4 with a length-5 chain -> err_overflow = 1, no out_valid, return to IDLE.
REQ-039 SHALL cover: fill the dictionary to 4096 -> dict_full = 1 and a further dict_we is ignored; then dict_clear -> dict_full = 0 and code 256 -> err_unknown = 1.
